// File: rtl/debug_pkg.sv
// Shared types for the debug trace capture block.
// Capture FSM encoding is visible on the cap_state port.
package debug_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } cap_state_t;

   localparam int DBG_PROBE_W = 8;

endpackage

// File: rtl/debug_trace_capture_if.sv
// Host read-back handshake for the trace buffer.
// master = host side, slave = capture block.
interface debug_trace_capture_if #(
   parameter int PROBE_W = 8
);

   logic               rd_req;
   logic               rd_ack;
   logic [PROBE_W-1:0] rd_data;
   logic               rd_last;

   modport master (
      output rd_req,
      input  rd_ack,
      input  rd_data,
      input  rd_last
   );

   modport slave (
      input  rd_req,
      output rd_ack,
      output rd_data,
      output rd_last
   );

endinterface

// File: rtl/debug_trace_ram.sv
// Trace sample store: one write port, one registered read port.
// Reads and writes never overlap (buffer is frozen while read).
module debug_trace_ram #(
   parameter  int PROBE_W = 8,
   parameter  int DEPTH   = 256,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [PROBE_W-1:0] wdata,
   input  logic               re,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [PROBE_W-1:0] rdata
);

   logic [PROBE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/debug_trace_capture.sv
// Debug probe trace capture: registered probe, mask/value trigger,
// circular pre/post-trigger buffer, one-word-per-request read-back.
module debug_trace_capture
   import debug_pkg::*;
#(
   parameter  int PROBE_W = DBG_PROBE_W,
   parameter  int DEPTH   = 256,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                clk_20mhz,
   input  logic                rst_20mhz,
   input  logic [PROBE_W-1:0]  probe,
   input  logic                arm,
   input  logic                abort,
   input  logic [PROBE_W-1:0]  trig_mask,
   input  logic [PROBE_W-1:0]  trig_value,
   input  logic                trig_edge,
   input  logic [ADDR_W-1:0]   pre_count,
   debug_trace_capture_if.slave rd,
   output logic [2:0]          cap_state,
   output logic                triggered
);

   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(DEPTH - 1);

   cap_state_t state, state_n;

   logic [PROBE_W-1:0] probe_q, mask_l, value_l, ram_q;
   logic               edge_l, match, match_d, hit;
   logic [ADDR_W-1:0]  pre_l, pre_clamp, fill, post, post_init;
   logic [ADDR_W-1:0]  wr_ptr, trig_ptr, rd_ptr, rd_cnt;
   logic               arm_go, wr_en, hit_go, done_go, rd_go, drop;
   logic               pend, last1;

   assign pre_clamp = (pre_count > MAX_IDX) ? MAX_IDX : pre_count;
   assign post_init = MAX_IDX - pre_l;
   assign match     = ((probe_q ^ value_l) & mask_l) == '0;
   assign hit       = edge_l ? (match & ~match_d) : match;
   assign drop      = abort | arm_go;
   assign cap_state = state;

   always_ff @(posedge clk_20mhz) begin
      if (rst_20mhz) state <= IDLE;
      else           state <= state_n;
   end

   always_comb begin
      state_n = state;
      arm_go  = 1'b0;
      wr_en   = 1'b0;
      hit_go  = 1'b0;
      done_go = 1'b0;
      rd_go   = 1'b0;
      unique case (state)
         IDLE: begin
            if (arm) begin
               arm_go  = 1'b1;
               state_n = (pre_clamp == '0) ? ARMED : PRE;
            end
         end
         PRE: begin
            wr_en = 1'b1;
            if (fill + ONE == pre_l) state_n = ARMED;
         end
         ARMED: begin
            wr_en = 1'b1;
            if (hit) begin
               hit_go = 1'b1;
               if (post_init == '0) begin
                  state_n = DONE;
                  done_go = 1'b1;
               end else begin
                  state_n = POST;
               end
            end
         end
         POST: begin
            wr_en = 1'b1;
            if (post == ONE) begin
               state_n = DONE;
               done_go = 1'b1;
            end
         end
         DONE: begin
            if (arm) begin
               arm_go  = 1'b1;
               state_n = (pre_clamp == '0) ? ARMED : PRE;
            end else if (rd.rd_req && !pend) begin
               rd_go = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (abort) begin
         state_n = IDLE;
         arm_go  = 1'b0;
         wr_en   = 1'b0;
         hit_go  = 1'b0;
         done_go = 1'b0;
         rd_go   = 1'b0;
      end
   end

   always_ff @(posedge clk_20mhz) begin
      if (rst_20mhz) begin
         probe_q    <= '0;
         mask_l     <= '0;
         value_l    <= '0;
         edge_l     <= 1'b0;
         match_d    <= 1'b0;
         pre_l      <= '0;
         fill       <= '0;
         post       <= '0;
         wr_ptr     <= '0;
         trig_ptr   <= '0;
         rd_ptr     <= '0;
         rd_cnt     <= '0;
         triggered  <= 1'b0;
         pend       <= 1'b0;
         last1      <= 1'b0;
         rd.rd_ack  <= 1'b0;
         rd.rd_data <= '0;
         rd.rd_last <= 1'b0;
      end else begin
         probe_q <= probe;
         match_d <= arm_go ? 1'b0 : match;
         if (arm_go) begin
            mask_l  <= trig_mask;
            value_l <= trig_value;
            edge_l  <= trig_edge;
            pre_l   <= pre_clamp;
            wr_ptr  <= '0;
            fill    <= '0;
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + ONE;
            fill   <= fill + ONE;
         end
         if (hit_go) begin
            trig_ptr <= wr_ptr;
            post     <= post_init;
         end else if (wr_en && state == POST) begin
            post <= post - ONE;
         end
         // Oldest kept sample sits pre slots behind the trigger sample.
         if (done_go) begin
            rd_ptr <= (hit_go ? wr_ptr : trig_ptr) - pre_l;
            rd_cnt <= '0;
         end
         if (drop)        triggered <= 1'b0;
         else if (hit_go) triggered <= 1'b1;
         if (rd_go) begin
            rd_ptr <= rd_ptr + ONE;
            rd_cnt <= rd_cnt + ONE;
            last1  <= (rd_cnt == MAX_IDX);
         end
         pend       <= rd_go;
         rd.rd_ack  <= pend & ~drop;
         rd.rd_last <= pend & ~drop & last1;
         if (pend && !drop) rd.rd_data <= ram_q;
      end
   end

   debug_trace_ram #(
      .PROBE_W (PROBE_W),
      .DEPTH   (DEPTH)
   ) u_ram (
      .clk   (clk_20mhz),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (probe_q),
      .re    (rd_go),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_debug_trace_capture.sv
// Bench for debug_trace_capture: directed scenarios plus random
// captures checked against a sample-history trigger model.
module tb_debug_trace_capture;
   import debug_pkg::*;

   localparam int PW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] probe = '0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [PW-1:0] trig_mask = '0;
   logic [PW-1:0] trig_value = '0;
   logic          trig_edge = 1'b0;
   logic [7:0]    pre_count = '0;
   logic [2:0]    cap_state;
   logic          triggered;

   debug_trace_capture_if #(.PROBE_W(PW)) rd_if ();

   debug_trace_capture #(
      .PROBE_W (PW),
      .DEPTH   (DEPTH)
   ) dut (
      .clk_20mhz  (clk),
      .rst_20mhz  (rst),
      .probe      (probe),
      .arm        (arm),
      .abort      (abort),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .trig_edge  (trig_edge),
      .pre_count  (pre_count),
      .rd         (rd_if),
      .cap_state  (cap_state),
      .triggered  (triggered)
   );

   always #25 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   logic [7:0] s[$];
   logic [7:0] rdbuf [DEPTH];
   int         t_cap, cur_pre, trig_c, done_c;
   int         gen_mode = 0;
   logic [7:0] gen_k = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx,
                      input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s[%0d]: got %0h, expected %0h", tag, idx, got, exp);
      end
   endtask

   function automatic logic [7:0] gen(input int c);
      case (gen_mode)
         0:       return 8'(c);
         1:       return gen_k;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic bit is_match(input logic [7:0] v,
                                   input logic [7:0] m,
                                   input logic [7:0] val);
      return ((v ^ val) & m) == 8'h00;
   endfunction

   // Sample k = probe on the k-th cycle counting from the arm cycle.
   function automatic int find_trig(input int pre, input logic [7:0] m,
                                    input logic [7:0] val, input bit e);
      bit cur, prev;
      for (int k = pre; k < s.size(); k++) begin
         cur  = is_match(s[k], m, val);
         prev = (k == 0) ? 1'b0 : is_match(s[k-1], m, val);
         if (e ? (cur && !prev) : cur) return k;
      end
      return -1;
   endfunction

   task automatic run_capture(input int pre, input logic [7:0] m,
                              input logic [7:0] val, input bit e);
      int c;
      s.delete();
      pre_count  = 8'(pre);
      trig_mask  = m;
      trig_value = val;
      trig_edge  = e;
      arm   = 1'b1;
      probe = gen(0);
      s.push_back(probe);
      tick();
      arm    = 1'b0;
      c      = 1;
      trig_c = -1;
      done_c = -1;
      while (done_c < 0 && c < 3000) begin
         if (triggered === 1'b1 && trig_c < 0) trig_c = c;
         if (cap_state === 3'd4) begin
            done_c = c;
         end else begin
            probe = gen(c);
            s.push_back(probe);
            tick();
            c++;
         end
      end
      cur_pre = pre;
      t_cap   = find_trig(pre, m, val, e);
      chk("trig_cycle", pre, trig_c, t_cap + 2);
      chk("done_cycle", pre, done_c, t_cap + 2 + (DEPTH - 1 - pre));
   endtask

   function automatic logic [7:0] exp_word(input int j);
      int idx;
      idx = t_cap - cur_pre + (j % DEPTH);
      if (idx < 0 || idx >= s.size()) return 8'hxx;
      return s[idx];
   endfunction

   task automatic read_word(input int j);
      logic [7:0] ew;
      ew = exp_word(j);
      rd_if.rd_req = 1'b1;
      tick();
      rd_if.rd_req = 1'b0;
      chk("ack_early", j, rd_if.rd_ack, 1'b0);
      tick();
      chk("ack", j, rd_if.rd_ack, 1'b1);
      chk("data", j, rd_if.rd_data, ew);
      chk("last", j, rd_if.rd_last, (j % DEPTH) == DEPTH - 1);
      rdbuf[j % DEPTH] = rd_if.rd_data;
      tick();
      chk("ack_pulse", j, rd_if.rd_ack, 1'b0);
      chk("hold", j, rd_if.rd_data, ew);
   endtask

   task automatic read_range(input int from, input int to);
      for (int j = from; j <= to; j++) read_word(j);
   endtask

   initial begin
      rd_if.rd_req = 1'b0;
      repeat (3) tick();
      chk("rst_state", 0, cap_state, 3'd0);
      chk("rst_ack", 0, rd_if.rd_ack, 1'b0);
      chk("rst_data", 0, rd_if.rd_data, 8'h00);
      chk("rst_last", 0, rd_if.rd_last, 1'b0);
      chk("rst_trig", 0, triggered, 1'b0);
      rst = 1'b0;
      tick();

      // Ramp probe, pre=4, exact match on A5.
      gen_mode = 0;
      run_capture(4, 8'hFF, 8'hA5, 1'b0);
      read_range(0, DEPTH - 1);
      chk("t1_w0", 0, rdbuf[0], 8'hA1);
      chk("t1_w3", 3, rdbuf[3], 8'hA4);
      chk("t1_w4", 4, rdbuf[4], 8'hA5);
      read_word(DEPTH);
      chk("t1_wrap", 0, rdbuf[0], 8'hA1);

      // Mask zero triggers immediately; overlapping request is ignored.
      gen_mode = 2;
      run_capture(0, 8'h00, 8'($urandom), 1'b0);
      chk("t2_trig", 0, trig_c, 2);
      rd_if.rd_req = 1'b1;
      tick();
      tick();
      rd_if.rd_req = 1'b0;
      chk("dbl_ack", 0, rd_if.rd_ack, 1'b1);
      chk("dbl_data", 0, rd_if.rd_data, exp_word(0));
      tick();
      chk("dbl_no_ack", 1, rd_if.rd_ack, 1'b0);
      tick();
      chk("dbl_no_ack", 2, rd_if.rd_ack, 1'b0);
      read_range(1, DEPTH - 1);

      // Abort while a read is in flight.
      rd_if.rd_req = 1'b1;
      tick();
      rd_if.rd_req = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abrt_rd_ack", 0, rd_if.rd_ack, 1'b0);
      chk("abrt_rd_state", 0, cap_state, 3'd0);
      tick();
      chk("abrt_rd_ack", 1, rd_if.rd_ack, 1'b0);

      // Clean re-arm after abort.
      run_capture(7, 8'h03, 8'($urandom), 1'b0);
      read_range(0, DEPTH - 1);

      // Held match: edge and level modes both fire once at once.
      gen_mode = 1;
      gen_k    = 8'h0F;
      run_capture(0, 8'hFF, 8'h0F, 1'b1);
      chk("t3_edge_trig", 0, trig_c, 2);
      chk("t3_stays", 0, triggered, 1'b1);
      read_range(0, 3);
      run_capture(0, 8'hFF, 8'h0F, 1'b0);
      chk("t3_level_trig", 0, trig_c, 2);
      read_range(0, 3);

      // ARMED: reads and re-arm are ignored.
      gen_k      = 8'h00;
      probe      = 8'h00;
      pre_count  = 8'd0;
      trig_mask  = 8'hFF;
      trig_value = 8'hFF;
      trig_edge  = 1'b0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      chk("armed_state", 0, cap_state, 3'd2);
      rd_if.rd_req = 1'b1;
      tick();
      rd_if.rd_req = 1'b0;
      chk("armed_no_ack", 0, rd_if.rd_ack, 1'b0);
      tick();
      chk("armed_no_ack", 1, rd_if.rd_ack, 1'b0);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      chk("armed_rearm", 0, cap_state, 3'd2);
      chk("armed_no_ack", 2, rd_if.rd_ack, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("armed_abort", 0, cap_state, 3'd0);

      // Abort during POST.
      gen_mode   = 2;
      trig_mask  = 8'h00;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      repeat (3) tick();
      chk("post_state", 0, cap_state, 3'd3);
      chk("post_trig", 0, triggered, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("post_abort", 0, cap_state, 3'd0);
      chk("post_abort_trig", 0, triggered, 1'b0);

      // pre at the clamp limit: trigger is the newest word.
      gen_mode = 0;
      run_capture(255, 8'hFF, 8'hA5, 1'b0);
      chk("t6_done_eq_trig", 0, done_c, trig_c);
      read_range(0, DEPTH - 1);
      chk("t6_w255", 255, rdbuf[255], 8'hA5);

      // Reset in the middle of PRE.
      pre_count  = 8'd200;
      trig_mask  = 8'hFF;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      repeat (10) tick();
      chk("midpre_state", 0, cap_state, 3'd1);
      rst = 1'b1;
      tick();
      chk("midpre_rst_state", 0, cap_state, 3'd0);
      chk("midpre_rst_data", 0, rd_if.rd_data, 8'h00);
      chk("midpre_rst_ack", 0, rd_if.rd_ack, 1'b0);
      chk("midpre_rst_last", 0, rd_if.rd_last, 1'b0);
      chk("midpre_rst_trig", 0, triggered, 1'b0);
      rst = 1'b0;
      tick();

      // Random captures.
      gen_mode = 2;
      for (int r = 0; r < 3; r++) begin
         run_capture(int'($urandom_range(0, 40)),
                     8'($urandom) & 8'h13 | 8'h01,
                     8'($urandom),
                     1'($urandom_range(0, 1)));
         read_range(0, DEPTH - 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
